// File: rtl/car_uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Holds the frame FSM states, default header byte and frame length.
package car_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GET_CMD,
    GET_ARG,
    GET_CHK
  } state_t;

  localparam logic [7:0] HEADER    = 8'hA5;
  localparam int         FRAME_LEN = 4;

  // 8-bit frame checksum, carry dropped
  function automatic logic [7:0] frame_sum(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream in / command-strobe out bundle of the frame parser.
// slave: parser side; master: UART driver + control logic side.
interface uart_cmd_parser_if;
  import car_uart_pkg::*;

  logic [7:0] in_rx_data;
  logic       in_rx_rq;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       chk_err;
  logic       timeout_err;
  logic [7:0] err_cnt;
  logic       busy;

  modport slave (
    input  in_rx_data,
    input  in_rx_rq,
    output cmd_valid,
    output cmd_code,
    output cmd_arg,
    output chk_err,
    output timeout_err,
    output err_cnt,
    output busy
  );

  modport master (
    output in_rx_data,
    output in_rx_rq,
    input  cmd_valid,
    input  cmd_code,
    input  cmd_arg,
    input  chk_err,
    input  timeout_err,
    input  err_cnt,
    input  busy
  );

endinterface

// File: rtl/cmd_gap_timer.sv
// Inter-byte gap timer: counts idle cycles inside a frame.
// Ports: clk, rst_n, clear, enable in; expire out (comb pulse).
module cmd_gap_timer #(
  parameter int TIMEOUT_CYCLES = 125000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // a byte event (clear) in the final cycle beats the timeout
  assign expire = enable & ~clear & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles header/cmd/arg/checksum frames from the UART byte stream.
// Ports: clk, reset (async active-low), bus (uart_cmd_parser_if.slave).
// Macro UART_CMD_TIMEOUT_EN adds the inter-byte gap timer.
module uart_cmd_parser
  import car_uart_pkg::*;
#(
  parameter logic [7:0] HDR = HEADER
`ifdef UART_CMD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 125000
`endif
) (
  input logic              clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);

  state_t     state, state_n;
  logic       rq_d;
  logic       byte_ev;
  logic [7:0] rx;
  logic       expire;

  logic [7:0] cmd_q, cmd_n;
  logic [7:0] arg_q, arg_n;
  logic [7:0] code_q, code_n;
  logic [7:0] carg_q, carg_n;
  logic [7:0] err_q, err_n;
  logic       valid_q, valid_n;
  logic       chk_q, chk_n;
  logic       tmo_q, tmo_n;

  // rising edge of the request: a held level is one byte
  assign byte_ev = bus.in_rx_rq & ~rq_d;
  assign rx      = bus.in_rx_data;

`ifdef UART_CMD_TIMEOUT_EN
  cmd_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap (
    .clk   (clk),
    .rst_n (reset),
    .clear (byte_ev | (state == IDLE)),
    .enable(state != IDLE),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cmd_n   = cmd_q;
    arg_n   = arg_q;
    code_n  = code_q;
    carg_n  = carg_q;
    valid_n = 1'b0;
    chk_n   = 1'b0;
    tmo_n   = 1'b0;
    err_n   = err_q;
    if (byte_ev) begin
      unique case (state)
        IDLE: begin
          if (rx == HDR) state_n = GET_CMD;
        end
        GET_CMD: begin
          cmd_n   = rx;
          state_n = GET_ARG;
        end
        GET_ARG: begin
          arg_n   = rx;
          state_n = GET_CHK;
        end
        GET_CHK: begin
          state_n = IDLE;
          if (rx == frame_sum(cmd_q, arg_q)) begin
            valid_n = 1'b1;
            code_n  = cmd_q;
            carg_n  = arg_q;
          end else begin
            chk_n = 1'b1;
          end
        end
      endcase
    end else if (expire) begin
      state_n = IDLE;
      tmo_n   = 1'b1;
    end
    if ((chk_n || tmo_n) && (err_q != 8'hFF)) begin
      err_n = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rq_d    <= 1'b0;
      cmd_q   <= '0;
      arg_q   <= '0;
      code_q  <= '0;
      carg_q  <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      chk_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_n;
      rq_d    <= bus.in_rx_rq;
      cmd_q   <= cmd_n;
      arg_q   <= arg_n;
      code_q  <= code_n;
      carg_q  <= carg_n;
      err_q   <= err_n;
      valid_q <= valid_n;
      chk_q   <= chk_n;
      tmo_q   <= tmo_n;
    end
  end

  assign bus.cmd_valid   = valid_q;
  assign bus.cmd_code    = code_q;
  assign bus.cmd_arg     = carg_q;
  assign bus.chk_err     = chk_q;
  assign bus.timeout_err = tmo_q;
  assign bus.err_cnt     = err_q;
  assign bus.busy        = (state != IDLE);

endmodule
